// File: rtl/clock_pkg.sv
// Shared constants and BCD helpers for the multifunction clock fields.
package clock_pkg;

  localparam logic [3:0] MODE_RUN = 4'b0001;
  localparam logic [3:0] MODE_SET = 4'b0010;
  localparam logic [3:0] MODE_ALM = 4'b0100;
  localparam logic [3:0] MODE_SW  = 4'b1000;

  localparam int BCD_W = 4;

  function automatic logic [31:0] bin_to_bcd(input int val);
    logic [31:0] r;
    int v;
    r = '0;
    v = val;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int bcd_to_bin(input logic [31:0] bcd);
    int r;
    r = 0;
    for (int i = 7; i >= 0; i--)
      r = r * 10 + int'(bcd[4*i +: 4]);
    return r;
  endfunction

endpackage

// File: rtl/bcd_mode_counter_if.sv
// Control and display bundle of one clock field.
interface bcd_mode_counter_if #(
  parameter int DIGITS = 2
);
  logic                  tick;
  logic                  sw_tick;
  logic                  stop;
  logic [3:0]            mode;
  logic                  sel;
  logic                  button;
  logic                  sw_clr;
  logic [4*DIGITS-1:0]   cntout;
  logic                  carry_time;
  logic                  carry_sw;

  modport master (
    output tick, sw_tick, stop, mode,
    output sel, button, sw_clr,
    input  cntout, carry_time, carry_sw
  );

  modport slave (
    input  tick, sw_tick, stop, mode,
    input  sel, button, sw_clr,
    output cntout, carry_time, carry_sw
  );
endinterface

// File: rtl/bcd_wrap_inc.sv
// Multi-digit BCD increment with wrap at MODULUS-1.
module bcd_wrap_inc
  import clock_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic [BCD_W*DIGITS-1:0] val,
  output logic [BCD_W*DIGITS-1:0] nxt,
  output logic                    wrap
);
  localparam int W = BCD_W * DIGITS;
  localparam logic [31:0] LAST32 =
    bin_to_bcd(MODULUS - 1);
  localparam logic [W-1:0] LAST = LAST32[W-1:0];

  logic [W-1:0] rip;
  logic         c;

  always_comb begin
    rip = val;
    c   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (val[4*i +: 4] == 4'd9) begin
          rip[4*i +: 4] = 4'd0;
        end else begin
          rip[4*i +: 4] = val[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
  end

  assign wrap = (val == LAST);
  assign nxt  = wrap ? '0 : rip;

endmodule

// File: rtl/bcd_mode_counter.sv
// One time field: time, alarm and stopwatch BCD channels
// with mode-selected display and cascadable carries.
module bcd_mode_counter
  import clock_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int MODULUS  = 60,
  parameter int BTN_SYNC = 2
) (
  input logic              clk,
  input logic              en,
  bcd_mode_counter_if.slave bus
);
  localparam int W = BCD_W * DIGITS;

  if (MODULUS < 2 || MODULUS > 10**DIGITS) begin : g_bad_mod
    $error("MODULUS out of range for DIGITS");
  end
  if (BTN_SYNC < 2) begin : g_bad_sync
    $error("BTN_SYNC must be at least 2");
  end

  logic [3:0] md;

  always_comb begin
    md = MODE_RUN;
    case (bus.mode)
      MODE_RUN, MODE_SET,
      MODE_ALM, MODE_SW: md = bus.mode;
      default:           md = MODE_RUN;
    endcase
  end

  logic [BTN_SYNC-1:0] sync;
  logic                btn_q;
  logic                btn_pulse;

  assign btn_pulse = sync[BTN_SYNC-1] & ~btn_q;

  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      sync  <= '0;
      btn_q <= 1'b0;
    end else begin
      sync  <= {sync[BTN_SYNC-2:0], bus.button};
      btn_q <= sync[BTN_SYNC-1];
    end
  end

  logic [W-1:0] t_q, a_q, s_q;
  logic [W-1:0] t_nxt, a_nxt, s_nxt;
  logic         t_wrap, a_wrap, s_wrap;
  logic         ct_q, cs_q;

  bcd_wrap_inc #(.DIGITS(DIGITS), .MODULUS(MODULUS))
    u_inc_t (.val(t_q), .nxt(t_nxt), .wrap(t_wrap));
  bcd_wrap_inc #(.DIGITS(DIGITS), .MODULUS(MODULUS))
    u_inc_a (.val(a_q), .nxt(a_nxt), .wrap(a_wrap));
  bcd_wrap_inc #(.DIGITS(DIGITS), .MODULUS(MODULUS))
    u_inc_s (.val(s_q), .nxt(s_nxt), .wrap(s_wrap));

  logic set_m, inc_t, inc_a, inc_s;

  // In set mode the button owns the time channel; ticks are dropped
  assign set_m = (md == MODE_SET);
  assign inc_t = !bus.stop &&
                 (set_m ? (btn_pulse && bus.sel) : bus.tick);
  assign inc_a = !bus.stop && (md == MODE_ALM) &&
                 bus.sel && btn_pulse;
  assign inc_s = !bus.stop && (md == MODE_SW) && bus.sw_tick;

  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      t_q  <= '0;
      a_q  <= '0;
      s_q  <= '0;
      ct_q <= 1'b0;
      cs_q <= 1'b0;
    end else begin
      ct_q <= inc_t && !set_m && t_wrap;
      if (inc_t) t_q <= t_nxt;
      if (inc_a) a_q <= a_nxt;
      if (bus.sw_clr) begin
        s_q  <= '0;
        cs_q <= 1'b0;
      end else begin
        cs_q <= inc_s && s_wrap;
        if (inc_s) s_q <= s_nxt;
      end
    end
  end

  logic unused;
  assign unused = a_wrap;

  always_comb begin
    bus.cntout = t_q;
    if (md == MODE_ALM)     bus.cntout = a_q;
    else if (md == MODE_SW) bus.cntout = s_q;
  end

  assign bus.carry_time = ct_q;
  assign bus.carry_sw   = cs_q;

endmodule

// File: tb/tb_bcd_mode_counter.sv
// Drives a MODULUS=60 and a MODULUS=24 field in lockstep and
// checks both against a queued integer reference.
module tb_bcd_mode_counter;
  import clock_pkg::*;

  logic       clk = 1'b0;
  logic       en  = 1'b0;
  logic       tick, sw_tick, stop, sel, button, sw_clr;
  logic [3:0] mode;

  always #5 clk = ~clk;

  bcd_mode_counter_if #(.DIGITS(2)) ifa ();
  bcd_mode_counter_if #(.DIGITS(2)) ifb ();

  assign ifa.tick = tick;    assign ifb.tick = tick;
  assign ifa.sw_tick = sw_tick;
  assign ifb.sw_tick = sw_tick;
  assign ifa.stop = stop;    assign ifb.stop = stop;
  assign ifa.mode = mode;    assign ifb.mode = mode;
  assign ifa.sel = sel;      assign ifb.sel = sel;
  assign ifa.button = button;
  assign ifb.button = button;
  assign ifa.sw_clr = sw_clr;
  assign ifb.sw_clr = sw_clr;

  bcd_mode_counter #(
    .DIGITS(2), .MODULUS(60), .BTN_SYNC(2)
  ) u_a (.clk(clk), .en(en), .bus(ifa.slave));

  bcd_mode_counter #(
    .DIGITS(2), .MODULUS(24), .BTN_SYNC(2)
  ) u_b (.clk(clk), .en(en), .bus(ifb.slave));

  typedef struct {
    logic [7:0] cnt;
    logic       ct;
    logic       cs;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  int mt[2], ma[2], ms[2];
  bit mct[2], mcs[2];
  bit bs0, bs1, bq;
  int modv[2] = '{60, 24};

  function automatic logic [7:0] tobcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [3:0] dec(input logic [3:0] m);
    if (m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000})
      return m;
    return 4'b0001;
  endfunction

  function automatic exp_t disp(input int k);
    exp_t e;
    int v;
    logic [3:0] d;
    d = dec(mode);
    v = (d == MODE_ALM) ? ma[k] :
        (d == MODE_SW)  ? ms[k] : mt[k];
    e.cnt = tobcd(v);
    e.ct  = mct[k];
    e.cs  = mcs[k];
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (q.size() < 2) begin
      chk({tag, "_queue"}, 8'(q.size()), 8'd2);
      return;
    end
    e = q.pop_front();
    chk({tag, "_a_cnt"}, ifa.cntout, e.cnt);
    chk({tag, "_a_ct"}, {7'd0, ifa.carry_time}, {7'd0, e.ct});
    chk({tag, "_a_cs"}, {7'd0, ifa.carry_sw}, {7'd0, e.cs});
    e = q.pop_front();
    chk({tag, "_b_cnt"}, ifb.cntout, e.cnt);
    chk({tag, "_b_ct"}, {7'd0, ifb.carry_time}, {7'd0, e.ct});
    chk({tag, "_b_cs"}, {7'd0, ifb.carry_sw}, {7'd0, e.cs});
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mt[k] = 0; ma[k] = 0; ms[k] = 0;
      mct[k] = 0; mcs[k] = 0;
    end
    bs0 = 0; bs1 = 0; bq = 0;
  endtask

  task automatic peek(input string tag);
    q.push_back(disp(0));
    q.push_back(disp(1));
    #1;
    compare(tag);
  endtask

  task automatic cyc(input string tag);
    logic [3:0] d;
    bit pulse, it, ia, is;
    d = dec(mode);
    pulse = bs1 && !bq;
    for (int k = 0; k < 2; k++) begin
      it = !stop && ((d == MODE_SET) ? (pulse && sel) : tick);
      ia = !stop && (d == MODE_ALM) && sel && pulse;
      is = !stop && (d == MODE_SW) && sw_tick;
      mct[k] = it && (d != MODE_SET) && (mt[k] == modv[k] - 1);
      if (it) mt[k] = (mt[k] + 1) % modv[k];
      if (ia) ma[k] = (ma[k] + 1) % modv[k];
      if (sw_clr) begin
        ms[k] = 0;
        mcs[k] = 0;
      end else begin
        mcs[k] = is && (ms[k] == modv[k] - 1);
        if (is) ms[k] = (ms[k] + 1) % modv[k];
      end
    end
    bq = bs1; bs1 = bs0; bs0 = button;
    q.push_back(disp(0));
    q.push_back(disp(1));
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic press(input string tag, input bit tog);
    button = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (tog) tick = ~tick;
      cyc(tag);
    end
    button = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (tog) tick = ~tick;
      cyc(tag);
    end
  endtask

  initial begin
    tick = 0; sw_tick = 0; stop = 0; sel = 0;
    button = 0; sw_clr = 0; mode = MODE_RUN;
    model_reset();
    #1;
    peek("reset");
    @(posedge clk);
    #1;
    en = 1'b1;

    tick = 1'b1;
    for (int i = 0; i < 61; i++) cyc("run");
    tick = 1'b0;

    mode = MODE_SET; sel = 1'b1;
    for (int i = 0; i < 3; i++) press("set", 1'b1);
    for (int i = 0; i < 60; i++) press("setwrap", 1'b1);
    tick = 1'b0;

    mode = MODE_ALM; sel = 1'b0; tick = 1'b1;
    for (int i = 0; i < 2; i++) press("alm_nosel", 1'b0);
    sel = 1'b1;
    for (int i = 0; i < 2; i++) press("alm_sel", 1'b0);
    mode = MODE_RUN;
    peek("switch_run");
    mode = MODE_ALM;
    peek("switch_alm");
    tick = 1'b0; sel = 1'b0;

    mode = MODE_SW;
    for (int i = 0; i < 25; i++) begin
      stop = (i >= 10 && i <= 14);
      sw_tick = 1'b1;
      cyc("sw_stop");
      sw_tick = 1'b0;
      stop = 1'b0;
      cyc("sw_gap");
    end
    sw_clr = 1'b1; sw_tick = 1'b1;
    cyc("sw_clr");
    sw_clr = 1'b0;
    for (int i = 0; i < 62; i++) cyc("sw_wrap");
    sw_tick = 1'b0;
    stop = 1'b1; sw_clr = 1'b1;
    cyc("sw_clr_stop");
    sw_clr = 1'b0;

    mode = MODE_RUN; tick = 1'b1; button = 1'b1;
    for (int i = 0; i < 4; i++) cyc("stop_all");
    stop = 1'b0; button = 1'b0;

    mode = 4'b0000;
    for (int i = 0; i < 3; i++) cyc("mode_zero");
    mode = 4'b0110;
    for (int i = 0; i < 3; i++) cyc("mode_multi");
    mode = MODE_RUN;

    for (int i = 0; i < 30 && mt[1] != 17; i++)
      cyc("to17");
    chk("reach17", tobcd(mt[1]), 8'h17);
    en = 1'b0;
    model_reset();
    peek("async_rst");
    @(posedge clk);
    #1;
    peek("rst_hold");
    en = 1'b1;
    for (int i = 0; i < 30; i++) cyc("resume");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
